// File: rtl/dq_rx_deser_x2.sv
// dq_rx_deser_x2: 2:1 DDR capture to 4-bit word deserialiser with optional bit-slip alignment.
// Define DQ_RX_BITSLIP_EN to include the ALIGNWD slip/lockout logic.
module dq_rx_deser_x2 #(
    parameter int ALIGN_LOCKOUT = 4,
    parameter int INIT_SLIP     = 0
) (
    input  logic       ECLK,
    input  logic       RST,
    input  logic       D0,
    input  logic       D1,
    input  logic       ALIGNWD,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic       UPDATE,
    output logic [1:0] SLIPCNT,
    output logic       ALIGNBUSY
);
    logic [3:0] h;
    logic       cnt;
    logic       hold;
    logic       upd;
    logic [4:0] hn;

    // One extra old bit so a slip of one can reach back past the 4-bit history
    assign hn  = {h[2:0], D0, D1};
    assign upd = cnt & ~hold;

`ifdef DQ_RX_BITSLIP_EN
    logic       accept;
    logic [3:0] lock;

    assign accept = ALIGNWD & ~ALIGNBUSY;
    // Odd-to-even slip needs one extra bit time, absorbed by freezing the phase
    assign hold   = accept & SLIPCNT[0];

    always_ff @(posedge ECLK) begin
        if (RST) begin
            SLIPCNT   <= 2'(INIT_SLIP);
            ALIGNBUSY <= 1'b0;
            lock      <= '0;
        end else if (accept) begin
            SLIPCNT   <= SLIPCNT + 2'd1;
            ALIGNBUSY <= 1'b1;
            lock      <= 4'(ALIGN_LOCKOUT - 1);
        end else if (ALIGNBUSY) begin
            if (lock == '0) ALIGNBUSY <= 1'b0;
            else lock <= lock - 4'd1;
        end
    end
`else
    logic unused_alignwd;

    assign unused_alignwd = ALIGNWD;
    assign hold           = 1'b0;
    assign SLIPCNT        = 2'(INIT_SLIP);
    assign ALIGNBUSY      = 1'b0;
`endif

    always_ff @(posedge ECLK) begin
        if (RST) begin
            h                <= '0;
            cnt              <= 1'b0;
            UPDATE           <= 1'b0;
            {Q0, Q1, Q2, Q3} <= '0;
        end else begin
            h      <= hn[3:0];
            cnt    <= hold ? cnt : ~cnt;
            UPDATE <= upd;
            if (upd) {Q0, Q1, Q2, Q3} <= SLIPCNT[0] ? hn[4:1] : hn[3:0];
        end
    end
endmodule
